// File: rtl/sram_pkg.sv
// Shared types and helpers for the parametrised single-port SRAM model.
package sram_pkg;

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } sram_state_e;

    localparam int SRAM_READ_LAT_MAX = 4;

    function automatic int seg_w(input int data_w, input int mask_w);
        return data_w / mask_w;
    endfunction

endpackage

// File: rtl/sram_delay_pipe.sv
// Valid+data shift pipeline of STAGES registers; valids reset asynchronously,
// data registers only load when a valid token moves into them.
module sram_delay_pipe #(
    parameter int STAGES = 1,
    parameter int DATA_W = 100
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_vld,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_vld,
    output logic [DATA_W-1:0] out_data
);

    generate
        if (STAGES == 0) begin : g_bypass
            assign out_vld  = in_vld;
            assign out_data = in_data;
        end else begin : g_pipe
            logic [STAGES-1:0] vld_q;
            logic [STAGES-1:0] vld_d;
            logic [DATA_W-1:0] data_q [STAGES];
            logic [DATA_W-1:0] data_d [STAGES];

            always_comb begin
                vld_d[0]  = in_vld;
                data_d[0] = in_vld ? in_data : data_q[0];
                for (int i = 1; i < STAGES; i++) begin
                    vld_d[i]  = vld_q[i-1];
                    data_d[i] = vld_q[i-1] ? data_q[i-1] : data_q[i];
                end
            end

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    vld_q <= '0;
                end else begin
                    vld_q <= vld_d;
                end
            end

            // Data has no reset: the valid bits qualify it everywhere downstream.
            always_ff @(posedge clock) begin
                for (int i = 0; i < STAGES; i++) begin
                    data_q[i] <= data_d[i];
                end
            end

            assign out_vld  = vld_q[STAGES-1];
            assign out_data = data_q[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/sram_array_rw_ext.sv
// Single-port masked SRAM with valid/ready requests, pipelined reads and a
// post-reset clear sweep. Optional macro SRAM_RDATA_HOLD_EN holds last read data.
module sram_array_rw_ext
    import sram_pkg::*;
#(
    parameter int ADDR_W   = 7,
    parameter int DATA_W   = 100,
    parameter int MASK_W   = 4,
    parameter int READ_LAT = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wmode,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [MASK_W-1:0] req_wmask,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              init_done
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int SEG_W = seg_w(DATA_W, MASK_W);

    generate
        if (READ_LAT < 1 || READ_LAT > SRAM_READ_LAT_MAX) begin : g_bad_read_lat
            $error("sram_array_rw_ext: READ_LAT must be in 1..%0d", SRAM_READ_LAT_MAX);
        end
        if (DATA_W % MASK_W != 0) begin : g_bad_mask_w
            $error("sram_array_rw_ext: DATA_W must be a multiple of MASK_W");
        end
    endgenerate

    sram_state_e       state_q;
    sram_state_e       state_d;
    logic [ADDR_W-1:0] init_cnt_q;
    logic [ADDR_W-1:0] init_cnt_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        case (state_q)
            ST_INIT: begin
                init_cnt_d = init_cnt_q + 1'b1;
                if (init_cnt_q == {ADDR_W{1'b1}}) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: state_d = ST_READY;
            default:  state_d = ST_INIT;
        endcase
    end

    assign req_ready = (state_q == ST_READY);
    assign init_done = (state_q == ST_READY);

    logic wr_acc;
    logic rd_acc;

    assign wr_acc = req_valid && req_ready && req_wmode;
    assign rd_acc = req_valid && req_ready && !req_wmode;

    logic [DATA_W-1:0] mem_q [DEPTH];

    // The sweep owns the port while initialising, so it never races a request.
    always_ff @(posedge clock) begin
        if (state_q == ST_INIT) begin
            mem_q[init_cnt_q] <= '0;
        end else if (wr_acc) begin
            for (int i = 0; i < MASK_W; i++) begin
                if (req_wmask[i]) begin
                    mem_q[req_addr][i*SEG_W +: SEG_W] <= req_wdata[i*SEG_W +: SEG_W];
                end
            end
        end
    end

    // Stage 1: array read register
    logic              rd_vld_q;
    logic              rd_vld_d;
    logic [DATA_W-1:0] rd_data_q;
    logic [DATA_W-1:0] rd_data_d;

    always_comb begin
        rd_vld_d  = rd_acc;
        rd_data_d = rd_data_q;
        if (rd_acc) begin
            rd_data_d = mem_q[req_addr];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_vld_q <= 1'b0;
        end else begin
            rd_vld_q <= rd_vld_d;
        end
    end

    always_ff @(posedge clock) begin
        rd_data_q <= rd_data_d;
    end

    // Stages 2..READ_LAT: response delay pipeline
    logic              pipe_vld;
    logic [DATA_W-1:0] pipe_data;

    sram_delay_pipe #(
        .STAGES (READ_LAT - 1),
        .DATA_W (DATA_W)
    ) u_delay_pipe (
        .clock    (clock),
        .reset    (reset),
        .in_vld   (rd_vld_q),
        .in_data  (rd_data_q),
        .out_vld  (pipe_vld),
        .out_data (pipe_data)
    );

    assign resp_valid = pipe_vld;

`ifdef SRAM_RDATA_HOLD_EN
    logic [DATA_W-1:0] hold_q;
    logic [DATA_W-1:0] hold_d;

    always_comb begin
        hold_d = hold_q;
        if (pipe_vld) begin
            hold_d = pipe_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end

    assign resp_rdata = pipe_vld ? pipe_data : hold_q;
`else
    assign resp_rdata = pipe_vld ? pipe_data : '0;
`endif

endmodule

// File: tb/tb_sram_array_rw_ext.sv
// Randomised bench for sram_array_rw_ext against an array/queue reference model.
module tb_sram_array_rw_ext;

    localparam int ADDR_W   = 7;
    localparam int DATA_W   = 100;
    localparam int MASK_W   = 4;
    localparam int READ_LAT = 2;
    localparam int DEPTH    = 128;
    localparam int SEG_W    = 25;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_wmode = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [MASK_W-1:0] req_wmask = '0;
    logic [DATA_W-1:0] req_wdata = '0;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              init_done;

    sram_array_rw_ext #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .MASK_W   (MASK_W),
        .READ_LAT (READ_LAT)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wmode  (req_wmode),
        .req_addr   (req_addr),
        .req_wmask  (req_wmask),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .init_done  (init_done)
    );

    always #5 clock = ~clock;

    typedef struct {
        int                due;
        logic [DATA_W-1:0] data;
    } resp_t;

    int                tests_run    = 0;
    int                tests_failed = 0;
    int                cyc          = 0;
    logic [DATA_W-1:0] ref_mem [DEPTH];
    resp_t             resp_q [$];
    bit                ready_m;
    int                sweep_m;
    logic [DATA_W-1:0] last_m;

    task automatic check_eq(input string tag, input logic [DATA_W-1:0] got,
                            input logic [DATA_W-1:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [DATA_W-1:0] rand_word();
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        return r[DATA_W-1:0];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        resp_q.delete();
        ready_m = 1'b0;
        sweep_m = 0;
        last_m  = '0;
    endtask

    // Called at a negedge: drive, clock, update the model, check at the next negedge.
    task automatic step(input bit v, input bit w, input logic [ADDR_W-1:0] a,
                        input logic [MASK_W-1:0] m, input logic [DATA_W-1:0] d);
        resp_t r;
        logic [DATA_W-1:0] exp_d;
        bit exp_v;
        req_valid = v;
        req_wmode = w;
        req_addr  = a;
        req_wmask = m;
        req_wdata = d;
        @(posedge clock);
        cyc++;
        if (!reset) begin
            if (v && ready_m) begin
                if (w) begin
                    for (int i = 0; i < MASK_W; i++)
                        if (m[i]) ref_mem[a][i*SEG_W +: SEG_W] = d[i*SEG_W +: SEG_W];
                end else begin
                    r.due  = cyc + READ_LAT - 1;
                    r.data = ref_mem[a];
                    resp_q.push_back(r);
                end
            end
            if (!ready_m) begin
                sweep_m++;
                if (sweep_m == DEPTH) ready_m = 1'b1;
            end
        end
        @(negedge clock);
        exp_v = (resp_q.size() > 0) && (resp_q[0].due == cyc);
        if (exp_v) begin
            exp_d  = resp_q[0].data;
            last_m = exp_d;
            void'(resp_q.pop_front());
        end else begin
`ifdef SRAM_RDATA_HOLD_EN
            exp_d = last_m;
`else
            exp_d = '0;
`endif
        end
        check_eq("resp_valid", resp_valid, exp_v);
        check_eq("resp_rdata", resp_rdata, exp_d);
        check_eq("req_ready", req_ready, ready_m);
        check_eq("init_done", init_done, ready_m);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic rand_step(input bit allow);
        bit v;
        logic [ADDR_W-1:0] a;
        v = allow && ($urandom_range(0, 3) != 0);
        a = ($urandom_range(0, 1) == 0) ? ADDR_W'($urandom_range(0, 7))
                                        : ADDR_W'($urandom_range(0, DEPTH - 1));
        step(v, 1'($urandom_range(0, 1)), a, MASK_W'($urandom_range(0, 15)), rand_word());
    endtask

    // Counts cycles until the DUT raises req_ready, with random traffic during the sweep.
    task automatic sweep_and_count(input string tag, input bit traffic);
        int n;
        n = 0;
        while (!req_ready && n < 300) begin
            if (traffic) rand_step(1'b1);
            else idle(1);
            n++;
        end
        check_eq(tag, n, DEPTH);
    endtask

    // Asserted at a negedge, mid-stream, so any in-flight response must vanish at once.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        check_eq("rst_resp_valid", resp_valid, 1'b0);
        check_eq("rst_resp_rdata", resp_rdata, '0);
        check_eq("rst_req_ready", req_ready, 1'b0);
        model_clear();
        @(negedge clock);
        idle(2);
        reset = 1'b0;
    endtask

    localparam logic [DATA_W-1:0] MERGE_EXP = {{25{1'b1}}, 25'h0, {25{1'b1}}, 25'h0};

    initial begin
        model_clear();
        @(negedge clock);
        @(negedge clock);
        check_eq("reset_req_ready", req_ready, 1'b0);
        check_eq("reset_init_done", init_done, 1'b0);
        check_eq("reset_resp_valid", resp_valid, 1'b0);
        check_eq("reset_resp_rdata", resp_rdata, '0);
        reset = 1'b0;
        sweep_and_count("sweep_len", 1'b0);

        step(1'b1, 1'b0, 7'h05, '0, '0);
        step(1'b0, 1'b0, '0, '0, '0);
        check_eq("rd05_valid", resp_valid, 1'b1);
        check_eq("rd05_data", resp_rdata, '0);

        step(1'b1, 1'b1, 7'h12, 4'b1111, '1);
        step(1'b1, 1'b1, 7'h12, 4'b0101, '0);
        step(1'b1, 1'b0, 7'h12, '0, '0);
        step(1'b0, 1'b0, '0, '0, '0);
        check_eq("mask_merge", resp_rdata, MERGE_EXP);
        idle(2);

        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, ADDR_W'(i), 4'hF, DATA_W'(10 + i));
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, ADDR_W'(i), '0, '0);
        idle(3);

        step(1'b1, 1'b1, 7'h7F, 4'hF, 100'h3);
        step(1'b1, 1'b0, 7'h7F, '0, '0);
        step(1'b1, 1'b1, 7'h7F, 4'h0, '1);
        check_eq("wr_then_rd", resp_rdata, 100'h3);
        step(1'b1, 1'b0, 7'h7F, '0, '0);
        step(1'b0, 1'b0, '0, '0, '0);
        check_eq("wmask0_noop", resp_rdata, 100'h3);

        step(1'b1, 1'b0, 7'h7F, '0, '0);
        step(1'b1, 1'b0, 7'h12, '0, '0);
        do_reset();
        sweep_and_count("resweep_len", 1'b1);
        step(1'b1, 1'b0, 7'h7F, '0, '0);
        step(1'b0, 1'b0, '0, '0, '0);
        check_eq("rd7f_cleared", resp_rdata, '0);

        step(1'b1, 1'b1, 7'h20, 4'hF, 100'h55);
        step(1'b1, 1'b0, 7'h20, '0, '0);
        idle(4);
`ifdef SRAM_RDATA_HOLD_EN
        check_eq("hold_rdata", resp_rdata, 100'h55);
`else
        check_eq("hold_rdata", resp_rdata, '0);
`endif

        for (int i = 0; i < 400; i++) rand_step(1'b1);
        idle(READ_LAT + 2);
        check_eq("queue_drained", resp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
